uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Parametrised successor to the fixed 8N1 UART: configurable data width, FIFO depth, runtime parity (none/even/odd) and stop bits (1/2).
- Per-byte parity and framing error reporting; sticky RX overrun flag.
- Integrated synchronous FIFOs (no vendor IP); 16x oversampling baud generator with runtime divisor.
- Sits between the pin-level rx/tx pair and the host/face-recognition control logic.

Parameters:
DBIT, 8, data bits per frame (5..9)
FIFO_AW, 4, log2 FIFO depth; each FIFO holds 2**FIFO_AW entries
DIV_BITS, 11, width of baud divisor

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
baud_div  in  DIV_BITS  tick period = baud_div+1 clk cycles; one bit = 16 ticks
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2  in  1  1 = two stop bits, 0 = one
rx  in  1  serial input, asynchronous
tx  out  1  serial output
w_data  in  DBIT  TX FIFO write data
wr_uart  in  1  push w_data
tx_full  out  1  TX FIFO full
tx_busy  out  1  transmitter not idle or TX FIFO non-empty
r_data  out  DBIT  RX FIFO head (show-ahead)
r_perr  out  1  parity error of head entry
r_ferr  out  1  framing error of head entry
rd_uart  in  1  pop RX FIFO
rx_empty  out  1  RX FIFO empty
rx_overrun  out  1  sticky: frame dropped because RX FIFO full
clr_overrun  in  1  clears rx_overrun
rx_count, tx_count  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset: tx=1, tx_full=0, tx_busy=0, rx_empty=1, r_data/r_perr/r_ferr=0, rx_overrun=0, counts=0; baud counter, FSMs (to IDLE), FIFO pointers cleared. Reset mid-frame aborts; any partial frame discarded, tx returns to 1 next cycle.
- Baud: counter 0..baud_div; tick one clk when counter==baud_div, then wraps to 0. baud_div=0 -> tick every clk.
- rx passes 2-FF synchroniser (2 clk latency) before FSM.
- Config (parity_mode, stop2) latched on leaving IDLE; changes mid-frame have no effect on that frame.
- RX FSM IDLE->START->DATA->PARITY->STOP->IDLE:
  IDLE: wait synced rx=0, clear tick count.
  START: after 7 ticks re-sample; rx=1 -> IDLE (glitch, nothing pushed); rx=0 -> DATA.
  DATA: sample every 16 ticks, LSB first, DBIT bits.
  PARITY (skipped if none): sample; perr = received parity != expected (even: XOR of data; odd: inverted).
  STOP: sample after 16 ticks per stop bit; any stop sample 0 -> ferr=1.
  Completion: push {ferr,perr,data} same cycle as last stop sample. If FIFO full (and no simultaneous pop) frame dropped, rx_overrun<=1.
- rx_overrun: clr_overrun wins over set in same cycle only if no drop that cycle; drop has priority.
- TX FSM IDLE->START->DATA->PARITY->STOP->IDLE: IDLE with FIFO non-empty: load head, pop FIFO same cycle, sync to next tick. Each bit held 16 ticks; start=0, data LSB first, parity bit if enabled, 1 or 2 stop bits =1. Back-to-back frames: next start bit immediately follows last stop bit period.
- FIFOs: show-ahead; wr when full ignored; rd when empty ignored, outputs unchanged. RX: push and pop same cycle when full both take effect, count unchanged. Flags/counts registered, updated cycle after push/pop.
- wr_uart with tx_full=1 ignored, no error flag.

Optional Feature:
UART_LOOPBACK_EN: defined -> adds input port loopback (1 bit); when 1, RX synchroniser input taken from internal tx, external rx ignored; tx pin still driven. Switching only legal while both FSMs idle. Undefined -> port absent, rx always external.

Test Plan:
- baud_div=3, none, 1 stop; write 0xA5 -> tx low 64 clk, then 1,0,1,0,0,1,0,1 each 64 clk, high 64 clk; tx_busy drops after stop.
- Drive rx frame 0x3C even parity, bit=64 clk -> rx_empty falls, r_data=0x3C, r_perr=0, r_ferr=0; rd_uart -> rx_empty=1.
- Same frame with flipped parity bit, odd mode; and stop bit held 0 -> r_perr=1 / r_ferr=1 respectively, data still 0x3C.
- FIFO_AW=2: receive 5 frames without reading -> rx_count=4, rx_overrun=1, first 4 bytes intact; clr_overrun -> 0.
- 8-cycle low pulse on rx -> START rejects, nothing pushed, rx_empty stays 1.
- Loopback on, stop2=1, odd parity, write 0x00,0xFF,0x81 back-to-back -> read same 3 bytes, no errors; reset asserted mid-frame -> tx=1, FIFOs empty next cycle.

Source files
------------

// File: rtl/uart_core.sv
// uart_core: parametrised UART with runtime parity/stop config, 16x oversampling and RX/TX FIFOs; optional UART_LOOPBACK_EN.
// Latency: rx pin -> RX FIFO push on the last stop-bit sample (+2 clk sync); TX FIFO head -> start bit on the next baud tick.
// Backpressure: wr_uart ignored while tx_full; RX frames dropped while RX FIFO full, reported by sticky rx_overrun.

module uart_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_i,
   input  logic [W-1:0] wr_dat_i,
   input  logic         rd_i,
   output logic [W-1:0] rd_dat_o,
   output logic         empty_o,
   output logic         full_o,
   output logic [AW:0]  count_o
);
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          empty_q;
   logic          full_q;
   logic          do_rd;
   logic          do_wr;

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
   assign do_rd = rd_i & ~empty_q;
   assign do_wr = wr_i & (~full_q | do_rd);

   // Next occupancy; flags are registered from it so they settle the cycle after the access.
   always_comb begin
      count_d = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + 1'b1;
      end else if (do_rd && !do_wr) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage, pointers and registered status; storage is cleared so the show-ahead head reads zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == FULL_CNT);
      end
   end

   assign rd_dat_o = mem_q[rd_ptr_q];
   assign empty_o  = empty_q;
   assign full_o   = full_q;
   assign count_o  = count_q;
endmodule

module uart_core #(
   parameter int DBIT     = 8,
   parameter int FIFO_AW  = 4,
   parameter int DIV_BITS = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DIV_BITS-1:0] baud_div,
   input  logic [1:0]          parity_mode,
   input  logic                stop2,
`ifdef UART_LOOPBACK_EN
   input  logic                loopback,
`endif
   input  logic                rx,
   output logic                tx,
   input  logic [DBIT-1:0]     w_data,
   input  logic                wr_uart,
   output logic                tx_full,
   output logic                tx_busy,
   output logic [DBIT-1:0]     r_data,
   output logic                r_perr,
   output logic                r_ferr,
   input  logic                rd_uart,
   output logic                rx_empty,
   output logic                rx_overrun,
   input  logic                clr_overrun,
   output logic [FIFO_AW:0]    rx_count,
   output logic [FIFO_AW:0]    tx_count
);
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   localparam logic [3:0] LAST_BIT = 4'(DBIT - 1);

   // runtime config decode, sampled by each FSM only when it leaves IDLE
   logic cfg_par_en;
   logic cfg_par_odd;
   assign cfg_par_en  = (parity_mode == 2'b01) | (parity_mode == 2'b10);
   assign cfg_par_odd = (parity_mode == 2'b10);

   // ---------------- baud generator ----------------
   logic [DIV_BITS-1:0] baud_cnt_q;
   logic                tick;

   // >= keeps the counter from running the full range if baud_div is lowered mid-count
   assign tick = (baud_cnt_q >= baud_div);

   // Free-running tick counter, one-clk tick every baud_div+1 cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_cnt_q <= '0;
      end else if (tick) begin
         baud_cnt_q <= '0;
      end else begin
         baud_cnt_q <= baud_cnt_q + 1'b1;
      end
   end

   // ---------------- rx synchroniser ----------------
   logic rx_src;
   logic rx_meta_q;
   logic rx_sync_q;
   logic tx_q;

`ifdef UART_LOOPBACK_EN
   assign rx_src = loopback ? tx_q : rx;
`else
   assign rx_src = rx;
`endif

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_src;
         rx_sync_q <= rx_meta_q;
      end
   end

   // ---------------- receiver ----------------
   state_t            rx_state_q;
   logic [3:0]        rx_s_q;
   logic [3:0]        rx_n_q;
   logic [DBIT-1:0]   rx_sh_q;
   logic              rx_perr_q;
   logic              rx_ferr_q;
   logic              rx_par_en_q;
   logic              rx_par_odd_q;
   logic              rx_stop2_q;
   logic              rx_push;
   logic              rx_drop;
   logic [DBIT+1:0]   rx_push_dat;
   logic [DBIT+1:0]   rx_head;
   logic              rx_full;

   // The final stop sample is folded straight into the pushed entry so the push lands on the sampling cycle.
   assign rx_push     = (rx_state_q == ST_STOP) & tick & (rx_s_q == 4'd15) &
                        (rx_n_q == {3'b000, rx_stop2_q});
   assign rx_push_dat = {rx_ferr_q | ~rx_sync_q, rx_perr_q, rx_sh_q};
   assign rx_drop     = rx_push & rx_full & ~rd_uart;

   // Receive FSM: mid-bit sampling at 16 ticks per bit, start bit re-checked at its centre.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q   <= ST_IDLE;
         rx_s_q       <= '0;
         rx_n_q       <= '0;
         rx_sh_q      <= '0;
         rx_perr_q    <= 1'b0;
         rx_ferr_q    <= 1'b0;
         rx_par_en_q  <= 1'b0;
         rx_par_odd_q <= 1'b0;
         rx_stop2_q   <= 1'b0;
      end else begin
         case (rx_state_q)
            ST_IDLE: begin
               rx_s_q <= '0;
               if (!rx_sync_q) begin
                  rx_state_q   <= ST_START;
                  rx_perr_q    <= 1'b0;
                  rx_ferr_q    <= 1'b0;
                  rx_par_en_q  <= cfg_par_en;
                  rx_par_odd_q <= cfg_par_odd;
                  rx_stop2_q   <= stop2;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (rx_s_q == 4'd7) begin
                     rx_s_q     <= '0;
                     rx_n_q     <= '0;
                     rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
                  end else begin
                     rx_s_q <= rx_s_q + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (rx_s_q == 4'd15) begin
                     rx_s_q  <= '0;
                     rx_sh_q <= {rx_sync_q, rx_sh_q[DBIT-1:1]};
                     if (rx_n_q == LAST_BIT) begin
                        rx_n_q     <= '0;
                        rx_state_q <= rx_par_en_q ? ST_PARITY : ST_STOP;
                     end else begin
                        rx_n_q <= rx_n_q + 1'b1;
                     end
                  end else begin
                     rx_s_q <= rx_s_q + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  if (rx_s_q == 4'd15) begin
                     rx_s_q     <= '0;
                     rx_perr_q  <= rx_sync_q ^ (^rx_sh_q) ^ rx_par_odd_q;
                     rx_state_q <= ST_STOP;
                  end else begin
                     rx_s_q <= rx_s_q + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (rx_s_q == 4'd15) begin
                     rx_s_q <= '0;
                     if (!rx_sync_q) begin
                        rx_ferr_q <= 1'b1;
                     end
                     if (rx_n_q == {3'b000, rx_stop2_q}) begin
                        rx_state_q <= ST_IDLE;
                     end else begin
                        rx_n_q <= rx_n_q + 1'b1;
                     end
                  end else begin
                     rx_s_q <= rx_s_q + 1'b1;
                  end
               end
            end
            default: rx_state_q <= ST_IDLE;
         endcase
      end
   end

   // Sticky overrun: a drop in the same cycle beats a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_overrun <= 1'b0;
      end else if (rx_drop) begin
         rx_overrun <= 1'b1;
      end else if (clr_overrun) begin
         rx_overrun <= 1'b0;
      end
   end

   uart_fifo #(.W(DBIT + 2), .AW(FIFO_AW)) u_rx_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (rx_push),
      .wr_dat_i (rx_push_dat),
      .rd_i     (rd_uart),
      .rd_dat_o (rx_head),
      .empty_o  (rx_empty),
      .full_o   (rx_full),
      .count_o  (rx_count)
   );

   assign r_data = rx_head[DBIT-1:0];
   assign r_perr = rx_head[DBIT];
   assign r_ferr = rx_head[DBIT+1];

   // ---------------- transmitter ----------------
   state_t          tx_state_q;
   logic [3:0]      tx_s_q;
   logic [3:0]      tx_n_q;
   logic [DBIT-1:0] tx_sh_q;
   logic            tx_par_q;
   logic            tx_par_en_q;
   logic            tx_stop2_q;
   logic            tx_armed_q;
   logic [DBIT-1:0] tx_head;
   logic            tx_empty;
   logic            tx_pop;
   logic            tx_last_stop_end;

   assign tx_last_stop_end = (tx_state_q == ST_STOP) & tick & (tx_s_q == 4'd15) &
                             (tx_n_q == {3'b000, tx_stop2_q});
   // Load from IDLE at once, or chain straight into the next frame at the end of the last stop bit.
   assign tx_pop = ~tx_empty & ((tx_state_q == ST_IDLE) | tx_last_stop_end);

   // Transmit FSM: every bit is held 16 ticks; from IDLE the start bit waits for the next tick to align.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q  <= ST_IDLE;
         tx_q        <= 1'b1;
         tx_s_q      <= '0;
         tx_n_q      <= '0;
         tx_sh_q     <= '0;
         tx_par_q    <= 1'b0;
         tx_par_en_q <= 1'b0;
         tx_stop2_q  <= 1'b0;
         tx_armed_q  <= 1'b0;
      end else begin
         if (tx_pop) begin
            tx_sh_q     <= tx_head;
            tx_par_q    <= (^tx_head) ^ cfg_par_odd;
            tx_par_en_q <= cfg_par_en;
            tx_stop2_q  <= stop2;
            tx_s_q      <= '0;
         end
         case (tx_state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (tx_pop) begin
                  tx_state_q <= ST_START;
                  tx_armed_q <= 1'b0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (!tx_armed_q) begin
                     tx_armed_q <= 1'b1;
                     tx_q       <= 1'b0;
                     tx_s_q     <= '0;
                  end else if (tx_s_q == 4'd15) begin
                     tx_s_q     <= '0;
                     tx_n_q     <= '0;
                     tx_q       <= tx_sh_q[0];
                     tx_state_q <= ST_DATA;
                  end else begin
                     tx_s_q <= tx_s_q + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tx_s_q == 4'd15) begin
                     tx_s_q <= '0;
                     if (tx_n_q == LAST_BIT) begin
                        tx_n_q <= '0;
                        if (tx_par_en_q) begin
                           tx_q       <= tx_par_q;
                           tx_state_q <= ST_PARITY;
                        end else begin
                           tx_q       <= 1'b1;
                           tx_state_q <= ST_STOP;
                        end
                     end else begin
                        tx_n_q  <= tx_n_q + 1'b1;
                        tx_q    <= tx_sh_q[1];
                        tx_sh_q <= tx_sh_q >> 1;
                     end
                  end else begin
                     tx_s_q <= tx_s_q + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  if (tx_s_q == 4'd15) begin
                     tx_s_q     <= '0;
                     tx_n_q     <= '0;
                     tx_q       <= 1'b1;
                     tx_state_q <= ST_STOP;
                  end else begin
                     tx_s_q <= tx_s_q + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tx_s_q == 4'd15) begin
                     if (!tx_pop) begin
                        tx_s_q <= '0;
                     end
                     if (tx_n_q == {3'b000, tx_stop2_q}) begin
                        if (tx_pop) begin
                           tx_q       <= 1'b0;
                           tx_armed_q <= 1'b1;
                           tx_state_q <= ST_START;
                        end else begin
                           tx_state_q <= ST_IDLE;
                        end
                     end else begin
                        tx_n_q <= tx_n_q + 1'b1;
                     end
                  end else begin
                     tx_s_q <= tx_s_q + 1'b1;
                  end
               end
            end
            default: tx_state_q <= ST_IDLE;
         endcase
      end
   end

   uart_fifo #(.W(DBIT), .AW(FIFO_AW)) u_tx_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (wr_uart),
      .wr_dat_i (w_data),
      .rd_i     (tx_pop),
      .rd_dat_o (tx_head),
      .empty_o  (tx_empty),
      .full_o   (tx_full),
      .count_o  (tx_count)
   );

   assign tx      = tx_q;
   assign tx_busy = (tx_state_q != ST_IDLE) | ~tx_empty;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized and directed checks of uart_core against a frame-level reference model.
// Timing: all stimulus and sampling on the falling clock edge.
// Model: serial frames built from the bit rules; RX FIFO modelled as a bounded queue with an overrun flag.

module tb_uart_core;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [10:0] baud_div = 11'd3;
   logic [1:0] parity_mode = 2'b00;
   logic       stop2 = 1'b0;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rx_pin;
   logic       tx;
   logic [7:0] w_data = 8'h00;
   logic       wr_uart = 1'b0;
   logic       tx_full;
   logic       tx_busy;
   logic [7:0] r_data;
   logic       r_perr;
   logic       r_ferr;
   logic       rd_uart = 1'b0;
   logic       rx_empty;
   logic       rx_overrun;
   logic       clr_overrun = 1'b0;
   logic [2:0] rx_count;
   logic [2:0] tx_count;

   int n_chk = 0;
   int n_fail = 0;

   // reference RX FIFO: {ferr, perr, data}, 4 entries
   logic [9:0] exp_q[$];
   logic       exp_ovr = 1'b0;

   always #5 clk = ~clk;

   // external loopback wire: tx fed back to rx when loop_en is set
   assign rx_pin = loop_en ? tx : rx_drv;

   uart_core #(.DBIT(8), .FIFO_AW(2), .DIV_BITS(11)) dut (
      .clk         (clk),
      .reset       (reset),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .rx          (rx_pin),
      .tx          (tx),
      .w_data      (w_data),
      .wr_uart     (wr_uart),
      .tx_full     (tx_full),
      .tx_busy     (tx_busy),
      .r_data      (r_data),
      .r_perr      (r_perr),
      .r_ferr      (r_ferr),
      .rd_uart     (rd_uart),
      .rx_empty    (rx_empty),
      .rx_overrun  (rx_overrun),
      .clr_overrun (clr_overrun),
      .rx_count    (rx_count),
      .tx_count    (tx_count)
   );

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] d);
      w_data = d; wr_uart = 1'b1;
      cyc(1);
      wr_uart = 1'b0;
   endtask

   task automatic pop_rx();
      rd_uart = 1'b1;
      cyc(1);
      rd_uart = 1'b0;
      cyc(1);
   endtask

   // drive one serial frame on rx; a bad stop holds the first stop bit low for 3/4 of its period
   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                             input logic flip, input logic bad, input int P);
      rx_drv = 1'b0; cyc(P);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i]; cyc(P);
      end
      if (pm == 2'b01 || pm == 2'b10) begin
         rx_drv = (^d) ^ (pm == 2'b10) ^ flip; cyc(P);
      end
      if (bad) begin
         rx_drv = 1'b0; cyc(3 * P / 4);
         rx_drv = 1'b1; cyc(P - 3 * P / 4);
      end else begin
         rx_drv = 1'b1; cyc(P);
      end
      if (s2) begin
         rx_drv = 1'b1; cyc(P);
      end
   endtask

   // model side of a received frame
   task automatic model_rx(input logic [7:0] d, input logic [1:0] pm, input logic flip, input logic bad);
      logic [9:0] e;
      e = {bad, flip & (pm == 2'b01 || pm == 2'b10), d};
      if (exp_q.size() < 4) exp_q.push_back(e);
      else exp_ovr = 1'b1;
   endtask

   // sample a tx frame at bit centres; bad flags a wrong start/parity/stop level or no frame at all
   task automatic decode_tx(input int P, input logic [1:0] pm, input logic s2,
                            output logic [7:0] d, output logic bad);
      int waited;
      d = 8'h00; bad = 1'b0; waited = 0;
      while (tx !== 1'b0 && waited < 40 * P) begin
         cyc(1); waited++;
      end
      if (tx !== 1'b0) begin
         bad = 1'b1;
         return;
      end
      cyc(P / 2);
      if (tx !== 1'b0) bad = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(P); d[i] = tx;
      end
      if (pm == 2'b01 || pm == 2'b10) begin
         cyc(P);
         if (tx !== ((^d) ^ (pm == 2'b10))) bad = 1'b1;
      end
      cyc(P);
      if (tx !== 1'b1) bad = 1'b1;
      if (s2) begin
         cyc(P);
         if (tx !== 1'b1) bad = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [20:0] got;
      reset = 1'b1; cyc(3); reset = 1'b0; cyc(1);
      got = {tx, tx_full, tx_busy, rx_empty, r_data, r_perr, r_ferr, rx_overrun, rx_count, tx_count};
      n_chk++;
      if (got !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0}) begin
         n_fail++; $display("FAIL reset_state: got %h expected %h", got,
                            {1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0});
      end
   endtask

   task automatic test_tx_a5();
      int waited;
      int low;
      logic [7:0] d;
      baud_div = 11'd3; parity_mode = 2'b00; stop2 = 1'b0;
      write_byte(8'hA5);
      waited = 0;
      while (tx !== 1'b0 && waited < 500) begin cyc(1); waited++; end
      low = 0;
      while (tx === 1'b0 && low < 500) begin cyc(1); low++; end
      n_chk++;
      if (low != 64) begin n_fail++; $display("FAIL tx_start_len: got %0d expected 64", low); end
      d = 8'h00;
      cyc(32); d[0] = tx;
      for (int i = 1; i < 8; i++) begin cyc(64); d[i] = tx; end
      n_chk++;
      if (d !== 8'hA5) begin n_fail++; $display("FAIL tx_a5_bits: got %h expected a5", d); end
      cyc(64);
      n_chk++;
      if ({tx, tx_busy} !== 2'b11) begin n_fail++; $display("FAIL tx_stop_busy: got %b expected 11", {tx, tx_busy}); end
      cyc(40);
      n_chk++;
      if ({tx, tx_busy, tx_count} !== {1'b1, 1'b0, 3'd0}) begin
         n_fail++; $display("FAIL tx_idle_after: got %b expected 10000", {tx, tx_busy, tx_count});
      end
   endtask

   task automatic test_rx_directed();
      logic [1:0] pms[3] = '{2'b01, 2'b10, 2'b01};
      logic       flips[3] = '{1'b0, 1'b1, 1'b0};
      logic       bads[3] = '{1'b0, 1'b0, 1'b1};
      baud_div = 11'd3; stop2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         parity_mode = pms[k];
         send_frame(8'h3C, pms[k], 1'b0, flips[k], bads[k], 64);
         model_rx(8'h3C, pms[k], flips[k], bads[k]);
         cyc(4);
         n_chk++;
         if ({rx_empty, rx_count} !== {1'b0, 3'd1}) begin
            n_fail++; $display("FAIL rx_dir_avail[%0d]: got %b expected 0001", k, {rx_empty, rx_count});
         end
         n_chk++;
         if ({r_ferr, r_perr, r_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL rx_dir_head[%0d]: got %h expected %h", k, {r_ferr, r_perr, r_data}, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop_rx();
         n_chk++;
         if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rx_dir_empty[%0d]: got %b expected 1", k, rx_empty); end
         cyc(3 * 64);
      end
   endtask

   task automatic test_glitch();
      baud_div = 11'd3; parity_mode = 2'b00;
      rx_drv = 1'b0; cyc(8); rx_drv = 1'b1;
      cyc(300);
      n_chk++;
      if ({rx_empty, rx_count} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL glitch_reject: got %b expected 1000", {rx_empty, rx_count});
      end
   endtask

   task automatic test_rand_rx();
      logic [7:0] d;
      logic [1:0] pm;
      logic s2, flip, bad;
      int P;
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom); pm = 2'($urandom_range(0, 3));
         s2 = 1'($urandom); flip = 1'($urandom); bad = ($urandom_range(0, 3) == 0);
         baud_div = 11'($urandom_range(0, 3)); P = 16 * (int'(baud_div) + 1);
         parity_mode = pm; stop2 = s2;
         cyc(2);
         send_frame(d, pm, s2, flip, bad, P);
         model_rx(d, pm, flip, bad);
         cyc(3);
         n_chk++;
         if ({rx_count, r_ferr, r_perr, r_data} !== {3'd1, exp_q[0]}) begin
            n_fail++; $display("FAIL rand_rx[%0d]: got cnt=%0d %h expected cnt=1 %h", k, rx_count,
                               {r_ferr, r_perr, r_data}, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop_rx();
         cyc(2 * P);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      baud_div = 11'd1; parity_mode = 2'b00; stop2 = 1'b0;
      cyc(2);
      for (int k = 0; k < 5; k++) begin
         d = 8'($urandom);
         send_frame(d, 2'b00, 1'b0, 1'b0, 1'b0, 32);
         model_rx(d, 2'b00, 1'b0, 1'b0);
         cyc(40);
      end
      n_chk++;
      if ({rx_count, rx_overrun} !== {3'(exp_q.size()), exp_ovr}) begin
         n_fail++; $display("FAIL overrun_set: got cnt=%0d ovr=%b expected cnt=%0d ovr=%b",
                            rx_count, rx_overrun, exp_q.size(), exp_ovr);
      end
      clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0; cyc(1);
      exp_ovr = 1'b0;
      n_chk++;
      if (rx_overrun !== exp_ovr) begin n_fail++; $display("FAIL overrun_clr: got %b expected 0", rx_overrun); end
      while (exp_q.size() > 0) begin
         n_chk++;
         if ({r_ferr, r_perr, r_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL overrun_data: got %h expected %h", {r_ferr, r_perr, r_data}, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop_rx();
      end
      n_chk++;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL overrun_drain: got %b expected 1", rx_empty); end
   endtask

   task automatic test_tx_full();
      logic [7:0] sent[6];
      logic [7:0] d;
      logic bad;
      int hi;
      baud_div = 11'd3; parity_mode = 2'($urandom_range(0, 3)); stop2 = 1'($urandom);
      cyc(2);
      for (int k = 0; k < 6; k++) begin
         sent[k] = 8'($urandom);
         w_data = sent[k]; wr_uart = 1'b1; cyc(1);
      end
      wr_uart = 1'b0;
      n_chk++;
      if ({tx_full, tx_count} !== {1'b1, 3'd4}) begin
         n_fail++; $display("FAIL tx_full_flag: got %b expected 1100", {tx_full, tx_count});
      end
      for (int k = 0; k < 5; k++) begin
         decode_tx(64, parity_mode, stop2, d, bad);
         n_chk++;
         if ({bad, d} !== {1'b0, sent[k]}) begin
            n_fail++; $display("FAIL tx_full_frame[%0d]: got bad=%b %h expected bad=0 %h", k, bad, d, sent[k]);
         end
      end
      hi = 0;
      for (int i = 0; i < 3 * 64; i++) begin cyc(1); if (tx === 1'b1) hi++; end
      n_chk++;
      if ({hi, tx_busy} !== {32'(3 * 64), 1'b0}) begin
         n_fail++; $display("FAIL tx_full_drop: got high=%0d busy=%b expected high=192 busy=0", hi, tx_busy);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h81};
      logic [7:0] d;
      int waited;
      loop_en = 1'b1; baud_div = 11'd1; parity_mode = 2'b10; stop2 = 1'b1;
      cyc(2);
      for (int k = 0; k < 3; k++) begin
         w_data = bytes[k]; wr_uart = 1'b1; cyc(1);
      end
      wr_uart = 1'b0;
      waited = 0;
      while (rx_count !== 3'd3 && waited < 3 * 13 * 32 + 400) begin cyc(1); waited++; end
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if ({rx_empty, r_ferr, r_perr, r_data} !== {3'b000, bytes[k]}) begin
            n_fail++; $display("FAIL loop_b2b[%0d]: got %h expected %h", k,
                               {rx_empty, r_ferr, r_perr, r_data}, {3'b000, bytes[k]});
         end
         pop_rx();
      end
      for (int k = 0; k < 3; k++) begin
         d = 8'($urandom);
         baud_div = 11'($urandom_range(0, 3)); parity_mode = 2'($urandom_range(0, 3)); stop2 = 1'($urandom);
         cyc(2);
         write_byte(d);
         waited = 0;
         while (rx_empty !== 1'b0 && waited < 1000) begin cyc(1); waited++; end
         cyc(2);
         n_chk++;
         if ({rx_empty, r_ferr, r_perr, r_data} !== {3'b000, d}) begin
            n_fail++; $display("FAIL loop_rand[%0d]: got %h expected %h", k,
                               {rx_empty, r_ferr, r_perr, r_data}, {3'b000, d});
         end
         pop_rx();
         cyc(100);
      end
      baud_div = 11'd3;
      write_byte(8'h5A);
      waited = 0;
      while (tx !== 1'b0 && waited < 500) begin cyc(1); waited++; end
      cyc(3 * 64);
      reset = 1'b1; cyc(1); reset = 1'b0;
      n_chk++;
      if ({tx, tx_busy, rx_empty, rx_count, tx_count} !== {1'b1, 1'b0, 1'b1, 3'd0, 3'd0}) begin
         n_fail++; $display("FAIL loop_reset: got %b expected 101000000", {tx, tx_busy, rx_empty, rx_count, tx_count});
      end
      cyc(20 * 64);
      n_chk++;
      if ({tx, rx_empty} !== 2'b11) begin
         n_fail++; $display("FAIL loop_after_reset: got %b expected 11", {tx, rx_empty});
      end
      loop_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_a5();
      test_rx_directed();
      test_glitch();
      test_rand_rx();
      test_overrun();
      test_tx_full();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
